// File: rtl/custom_seq_pkg.sv
// custom_seq_pkg: legal custom-sequence values, successor/legality helpers and checker states.
package custom_seq_pkg;

    localparam logic [3:0] SEQ_1  = 4'd1;
    localparam logic [3:0] SEQ_2  = 4'd2;
    localparam logic [3:0] SEQ_3  = 4'd3;
    localparam logic [3:0] SEQ_5  = 4'd5;
    localparam logic [3:0] SEQ_9  = 4'd9;
    localparam logic [3:0] SEQ_11 = 4'd11;
    localparam logic [3:0] SEQ_12 = 4'd12;
    localparam logic [3:0] SEQ_15 = 4'd15;

    typedef enum logic {HUNT, LOCKED} state_t;

    // Illegal values map to 0, which is itself never a legal successor.
    function automatic logic [3:0] seq_succ(input logic [3:0] v);
        case (v)
            SEQ_1:   return SEQ_2;
            SEQ_2:   return SEQ_3;
            SEQ_3:   return SEQ_5;
            SEQ_5:   return SEQ_9;
            SEQ_9:   return SEQ_11;
            SEQ_11:  return SEQ_12;
            SEQ_12:  return SEQ_15;
            SEQ_15:  return SEQ_1;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic seq_legal(input logic [3:0] v);
        return seq_succ(v) != 4'd0;
    endfunction

endpackage

// File: rtl/custom_seq_lookup.sv
// custom_seq_lookup: combinational successor and legality lookup for one sequence value.
module custom_seq_lookup
    import custom_seq_pkg::*;
(
    input  logic [3:0] prev,
    output logic [3:0] succ,
    output logic       legal
);

    assign succ  = seq_succ(prev);
    assign legal = seq_legal(prev);

endmodule

// File: rtl/custom_seq_checker.sv
// custom_seq_checker: locks onto the 1-2-3-5-9-11-12-15 sequence and reports errors and completed cycles.
module custom_seq_checker
    import custom_seq_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int LOCK_LEN = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [3:0]       in_q,
    output logic             locked,
    output logic [3:0]       expected,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic             wrap_pulse,
    output logic [CNT_W-1:0] wrap_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [2:0] LOCK_RUN = 3'(LOCK_LEN);

    state_t     state;
    logic [3:0] prev;
    logic       prev_vld;
    logic [2:0] run;
    logic [3:0] prev_succ;
    logic       prev_legal;
    logic [3:0] in_succ;
    logic       in_legal;
    logic       good;
    logic       wrap;

    custom_seq_lookup u_prev (.prev(prev), .succ(prev_succ), .legal(prev_legal));
    custom_seq_lookup u_in   (.prev(in_q), .succ(in_succ),   .legal(in_legal));

    assign good   = prev_vld && prev_legal && in_q == prev_succ;
    assign wrap   = good && prev == SEQ_15;
    assign locked = state == LOCKED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            prev       <= 4'd0;
            prev_vld   <= 1'b0;
            run        <= 3'd0;
            expected   <= 4'd0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
            err_cnt    <= '0;
        end else if (clr) begin
            state      <= HUNT;
            prev_vld   <= 1'b0;
            run        <= 3'd0;
            expected   <= 4'd0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            if (in_valid) begin
                // A legal sample always becomes the new reference, even when it was a bad transition.
                prev     <= in_legal ? in_q : prev;
                prev_vld <= in_legal;
                expected <= in_legal ? in_succ : 4'd0;
                if (state == HUNT) begin
                    if (!good) begin
                        run <= 3'd0;
                    end else if (run + 3'd1 == LOCK_RUN) begin
                        state <= LOCKED;
                        run   <= 3'd0;
                    end else begin
                        run <= run + 3'd1;
                    end
                end else if (good) begin
                    if (wrap) begin
                        wrap_pulse <= 1'b1;
                        wrap_cnt   <= wrap_cnt + CNT_W'(1);
                    end
                end else begin
                    err_pulse  <= 1'b1;
                    err_sticky <= 1'b1;
                    err_cnt    <= &err_cnt ? err_cnt : err_cnt + CNT_W'(1);
                    state      <= HUNT;
                    run        <= 3'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_custom_seq_checker.sv
// tb_custom_seq_checker: directed scenario checks of custom_seq_checker with CNT_W=2, LOCK_LEN=2.
module tb_custom_seq_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_q = 4'd0;
    logic       locked;
    logic [3:0] expected;
    logic       err_pulse;
    logic       err_sticky;
    logic       wrap_pulse;
    logic [1:0] wrap_cnt;
    logic [1:0] err_cnt;
    int         total = 0;
    int         bad = 0;

    custom_seq_checker #(.CNT_W(2), .LOCK_LEN(2)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_q(in_q),
        .locked(locked), .expected(expected), .err_pulse(err_pulse), .err_sticky(err_sticky),
        .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input logic v, input logic [3:0] q);
        in_valid = v;
        in_q = q;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({locked, expected, err_pulse, err_sticky, wrap_pulse, wrap_cnt, err_cnt} !== 12'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {locked, expected, err_pulse, err_sticky, wrap_pulse, wrap_cnt, err_cnt});
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lock();
        logic [3:0] seq [3] = '{4'd1, 4'd2, 4'd3};
        logic [3:0] exp [3] = '{4'd2, 4'd3, 4'd5};
        logic       lk  [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, seq[i]);
            total++;
            if (locked !== lk[i] || expected !== exp[i] || err_cnt !== 2'd0) begin
                bad++;
                $display("FAIL lock_step%0d got locked=%b exp=%0d errc=%0d want locked=%b exp=%0d errc=0", i, locked, expected, err_cnt, lk[i], exp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] seq [6] = '{4'd5, 4'd9, 4'd11, 4'd12, 4'd15, 4'd1};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, seq[i]);
            total++;
            if (wrap_pulse !== (i == 5) || err_pulse !== 1'b0 || locked !== 1'b1) begin
                bad++;
                $display("FAIL wrap_step%0d got wrap=%b err=%b locked=%b want wrap=%b err=0 locked=1", i, wrap_pulse, err_pulse, locked, i == 5);
            end
        end
        total++;
        if (wrap_cnt !== 2'd1 || expected !== 4'd2) begin
            bad++;
            $display("FAIL wrap_cnt got cnt=%0d exp=%0d want cnt=1 exp=2", wrap_cnt, expected);
        end
        step(1'b0, 4'd0);
        total++;
        if (wrap_pulse !== 1'b0 || wrap_cnt !== 2'd1) begin
            bad++;
            $display("FAIL wrap_idle got wrap=%b cnt=%0d want wrap=0 cnt=1", wrap_pulse, wrap_cnt);
        end
    endtask

    task automatic test_error();
        step(1'b1, 4'd2);
        step(1'b1, 4'd3);
        step(1'b1, 4'd5);
        step(1'b1, 4'd11);
        total++;
        if (err_pulse !== 1'b1 || err_cnt !== 2'd1 || err_sticky !== 1'b1 || locked !== 1'b0 || expected !== 4'd12 || wrap_pulse !== 1'b0) begin
            bad++;
            $display("FAIL error_inject got err=%b cnt=%0d sticky=%b locked=%b exp=%0d wrap=%b want 1 1 1 0 12 0", err_pulse, err_cnt, err_sticky, locked, expected, wrap_pulse);
        end
        step(1'b1, 4'd12);
        total++;
        if (err_pulse !== 1'b0 || locked !== 1'b0 || err_sticky !== 1'b1) begin
            bad++;
            $display("FAIL error_relock1 got err=%b locked=%b sticky=%b want 0 0 1", err_pulse, locked, err_sticky);
        end
        step(1'b1, 4'd15);
        total++;
        if (locked !== 1'b1 || err_cnt !== 2'd1 || expected !== 4'd1) begin
            bad++;
            $display("FAIL error_relock2 got locked=%b cnt=%0d exp=%0d want 1 1 1", locked, err_cnt, expected);
        end
    endtask

    task automatic test_gaps();
        logic [3:0] seq [4] = '{4'd1, 4'd2, 4'd3, 4'd5};
        logic [3:0] exp [4] = '{4'd2, 4'd3, 4'd5, 4'd9};
        logic       lk  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_clr();
        total++;
        if (wrap_cnt !== 2'd0 || err_cnt !== 2'd0 || err_sticky !== 1'b0 || locked !== 1'b0 || expected !== 4'd0) begin
            bad++;
            $display("FAIL gaps_clr got wc=%0d ec=%0d sticky=%b locked=%b exp=%0d want all 0", wrap_cnt, err_cnt, err_sticky, locked, expected);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, seq[i]);
            total++;
            if (locked !== lk[i] || expected !== exp[i]) begin
                bad++;
                $display("FAIL gaps_step%0d got locked=%b exp=%0d want locked=%b exp=%0d", i, locked, expected, lk[i], exp[i]);
            end
            for (int g = 0; g < 3; g++) begin
                step(1'b0, 4'd7);
                total++;
                if (err_pulse !== 1'b0 || wrap_pulse !== 1'b0 || locked !== lk[i] || expected !== exp[i]) begin
                    bad++;
                    $display("FAIL gaps_idle%0d_%0d got err=%b wrap=%b locked=%b exp=%0d want 0 0 %b %0d", i, g, err_pulse, wrap_pulse, locked, expected, lk[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_saturate();
        logic [3:0] bad_v [5] = '{4'd11, 4'd2, 4'd11, 4'd2, 4'd11};
        logic [3:0] ok1   [5] = '{4'd12, 4'd3, 4'd12, 4'd3, 4'd12};
        logic [3:0] ok2   [5] = '{4'd15, 4'd5, 4'd15, 4'd5, 4'd15};
        logic [1:0] ec    [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, bad_v[i]);
            total++;
            if (err_pulse !== 1'b1 || err_cnt !== ec[i] || locked !== 1'b0) begin
                bad++;
                $display("FAIL sat_err%0d got err=%b cnt=%0d locked=%b want 1 %0d 0", i, err_pulse, err_cnt, locked, ec[i]);
            end
            step(1'b1, ok1[i]);
            step(1'b1, ok2[i]);
        end
        total++;
        if (err_cnt !== 2'd3 || err_sticky !== 1'b1 || locked !== 1'b1) begin
            bad++;
            $display("FAIL sat_hold got cnt=%0d sticky=%b locked=%b want 3 1 1", err_cnt, err_sticky, locked);
        end
        in_valid = 1'b1;
        in_q = 4'd3;
        do_clr();
        in_valid = 1'b0;
        total++;
        if (wrap_cnt !== 2'd0 || err_cnt !== 2'd0 || err_sticky !== 1'b0 || locked !== 1'b0 || expected !== 4'd0 || err_pulse !== 1'b0) begin
            bad++;
            $display("FAIL sat_clr got wc=%0d ec=%0d sticky=%b locked=%b exp=%0d err=%b want all 0", wrap_cnt, err_cnt, err_sticky, locked, expected, err_pulse);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 4'd1);
        step(1'b1, 4'd2);
        step(1'b1, 4'd3);
        step(1'b1, 4'd9);
        total++;
        if (locked !== 1'b0 || err_sticky !== 1'b1) begin
            bad++;
            $display("FAIL async_pre got locked=%b sticky=%b want 0 1", locked, err_sticky);
        end
        step(1'b1, 4'd11);
        step(1'b1, 4'd12);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({locked, expected, err_pulse, err_sticky, wrap_pulse, wrap_cnt, err_cnt} !== 12'd0) begin
            bad++;
            $display("FAIL async_clear got=%h want=0", {locked, expected, err_pulse, err_sticky, wrap_pulse, wrap_cnt, err_cnt});
        end
        #1;
        rst_n = 1'b1;
        step(1'b1, 4'd3);
        total++;
        if (err_pulse !== 1'b0 || locked !== 1'b0 || expected !== 4'd5) begin
            bad++;
            $display("FAIL async_first got err=%b locked=%b exp=%0d want 0 0 5", err_pulse, locked, expected);
        end
        step(1'b1, 4'd5);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL async_second got locked=%b want 0", locked);
        end
        step(1'b1, 4'd9);
        total++;
        if (locked !== 1'b1 || expected !== 4'd11) begin
            bad++;
            $display("FAIL async_relock got locked=%b exp=%0d want 1 11", locked, expected);
        end
    endtask

    task automatic test_illegal();
        step(1'b1, 4'd0);
        total++;
        if (err_pulse !== 1'b1 || locked !== 1'b0 || expected !== 4'd0) begin
            bad++;
            $display("FAIL illegal_zero got err=%b locked=%b exp=%0d want 1 0 0", err_pulse, locked, expected);
        end
        step(1'b1, 4'd11);
        total++;
        if (locked !== 1'b0 || expected !== 4'd12) begin
            bad++;
            $display("FAIL illegal_after got locked=%b exp=%0d want 0 12", locked, expected);
        end
        step(1'b1, 4'd12);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL illegal_run got locked=%b want 0", locked);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_wrap();
        test_error();
        test_gaps();
        test_saturate();
        test_async_reset();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/custom_seq_checker.md
Name: custom_seq_checker

Overview:
- Downstream monitor for the 4-bit custom sequence counter. Legal cycle: 1-2-3-5-9-11-12-15, then back to 1.
- Samples the counter value on qualified cycles and checks every transition against the legal successor.
- Reports lock status, sequence errors and completed cycles to the lab top and debug LEDs.

Parameters:
- CNT_W, 8, width of wrap_cnt and err_cnt.
- LOCK_LEN, 2, consecutive correct transitions needed to enter LOCKED (range 1..7).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of counters, sticky flag and FSM; priority over in_valid.
- in_valid  in  1  in_q is sampled this cycle.
- in_q  in  4  counter value under check.
- locked  out  1  FSM is in LOCKED.
- expected  out  4  legal successor of the last accepted sample; 0 when no valid previous sample.
- err_pulse  out  1  one-cycle pulse on a bad transition while LOCKED.
- err_sticky  out  1  set by err_pulse; cleared only by reset or clr.
- wrap_pulse  out  1  one-cycle pulse on a good 15->1 transition while LOCKED.
- wrap_cnt  out  CNT_W  number of completed cycles, modulo 2^CNT_W.
- err_cnt  out  CNT_W  number of errors, saturating at all-ones.

Behaviour:
- Reset (rst_n low, asynchronous): state=HUNT, prev=0, prev_vld=0, run=0. All outputs are 0.
- Legal set: {1,2,3,5,9,11,12,15}. succ(): 1->2, 2->3, 3->5, 5->9, 9->11, 11->12, 12->15, 15->1. Every other value (including 0) is illegal.
- All outputs are registered. Responses appear in the cycle after the sampling edge.
- in_valid=0: state, prev and counters hold. Pulses are 0.
- On each cycle with in_valid=1:
  - good transition: prev_vld=1 and in_q==succ(prev).
  - bad transition: any other case, including an illegal in_q.
- prev/prev_vld update:
  - legal in_q: prev<=in_q, prev_vld<=1.
  - illegal in_q: prev_vld<=0.
- HUNT state:
  - good transition: run++. When run reaches LOCK_LEN, go to LOCKED and set run=0.
  - bad transition: run<=0. No error is reported.
- LOCKED state:
  - good transition: stay in LOCKED. If prev==15 and in_q==1: wrap_pulse=1, wrap_cnt++ (wraps modulo 2^CNT_W).
  - bad transition: err_pulse=1, err_cnt++ (saturating), err_sticky<=1, go to HUNT, run<=0.
  - A bad sample with a legal value becomes the new prev, so relock can start from it immediately.
- expected = prev_vld ? succ(prev) : 0.
- clr=1: state=HUNT, run=0, prev_vld=0, both counters 0, err_sticky=0, no pulses. The sample on that cycle is ignored.
- Reset asserted mid-LOCKED: outputs clear immediately and asynchronously. The first sample after release cannot be good.
- err_pulse and wrap_pulse are never both high in the same cycle.

Decomposition:
- custom_seq_pkg holds:
  - sequence constants SEQ_1..SEQ_15;
  - function seq_succ(4-bit) -> 4-bit;
  - function seq_legal(4-bit) -> bit;
  - state enum {HUNT, LOCKED}.
- Sub-module custom_seq_lookup is combinational: given prev, it outputs succ and legal. It is shared with a future generator-side assertion block.
- The FSM and counters stay in custom_seq_checker.

Test Plan:
- Reset, then in_valid=1 with 1,2,3 on consecutive cycles. locked=1 the cycle after sampling 3; expected=5; err_cnt=0.
- Locked stream 5,9,11,12,15,1. One wrap_pulse, the cycle after sampling 1; wrap_cnt=1; err_pulse never high.
- Locked at prev=5, inject 11. err_pulse for one cycle, err_cnt=1, err_sticky=1, locked=0. Then feed 12,15: relock with locked=1 after 15 (LOCK_LEN=2).
- Gaps: feed 1,2,3,5 with in_valid=0 for 3 cycles between samples. Same responses as the gap-free case; no pulses during gaps.
- CNT_W=2: force 5 locked errors. err_cnt sticks at 3. Then clr: all counters 0, err_sticky=0, locked=0.
- Assert rst_n low asynchronously mid-LOCKED (mid-cycle). All outputs are 0 before the next clock edge. After release, the first sample 3 gives no error and is not locked; a following 5 counts toward lock.
